underserved_mem_arb: RTL and testbench

Arbiter and sequencer for the single SPI flash read port. It shares the port between the SERV instruction bus and data-bus reads, and routes data-bus writes to the GPIO register. It adds a one-word last-read buffer so that repeated fetches of the same word skip the SPI transaction. A timeout watchdog keeps a dead or missing flash from hanging the core. It sits between `serv_top` and `spimemio`/`subservient_gpio` in the top level.

---
 rtl/underserved_mem_arb.sv | 129 ++++++++++++
 tb/tb_underserved_mem_arb.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/underserved_mem_arb.sv
// underserved_mem_arb: shares the SPI flash read port between ibus and dbus reads, with a last-read buffer and timeout
module underserved_mem_arb #(
   parameter int AW      = 24,
   parameter int TIMEOUT = 1024,
   parameter bit BUF_EN  = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   i_ibus_adr,
   input  logic          i_ibus_cyc,
   output logic [31:0]   o_ibus_rdt,
   output logic          o_ibus_ack,
   input  logic [31:0]   i_dbus_adr,
   input  logic [31:0]   i_dbus_dat,
   input  logic          i_dbus_we,
   input  logic          i_dbus_cyc,
   output logic [31:0]   o_dbus_rdt,
   output logic          o_dbus_ack,
   output logic          o_gpio_stb,
   output logic          o_gpio_dat,
   input  logic          i_gpio_ack,
   output logic          o_mem_valid,
   output logic [AW-1:0] o_mem_addr,
   input  logic          i_mem_ready,
   input  logic [31:0]   i_mem_rdata,
   input  logic          i_flush,
   output logic          o_timeout
);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MEM  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          sel_q, sel_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   rsp_q, rsp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;
   logic          buf_valid_q, buf_valid_d;
   logic [AW-1:0] buf_addr_q, buf_addr_d;
   logic [31:0]   buf_data_q, buf_data_d;
   logic          dbus_rd, hit;
   logic [AW-1:0] req_addr;
   logic          unused_ok;

   assign unused_ok   = ^{i_ibus_adr[31:AW], i_ibus_adr[1:0], i_dbus_adr[31:AW], i_dbus_adr[1:0], i_dbus_dat[31:1]};
   assign o_gpio_stb  = i_dbus_cyc & i_dbus_we;
   assign o_gpio_dat  = i_dbus_dat[0];
   assign o_mem_valid = state_q == MEM;
   assign o_mem_addr  = addr_q;
   assign o_ibus_rdt  = rsp_q;
   assign o_dbus_rdt  = rsp_q;
   assign o_timeout   = timeout_q;
   assign o_ibus_ack  = (state_q == RESP) & ~sel_q & i_ibus_cyc;
   assign o_dbus_ack  = o_gpio_stb ? i_gpio_ack : (state_q == RESP) & sel_q & i_dbus_cyc;

   // Pick the pending read (dbus first) and look it up in the last-read buffer
   always_comb begin
      dbus_rd  = i_dbus_cyc & ~i_dbus_we;
      req_addr = dbus_rd ? {i_dbus_adr[AW-1:2], 2'b00} : {i_ibus_adr[AW-1:2], 2'b00};
      hit      = BUF_EN && buf_valid_q && (req_addr == buf_addr_q);
   end

   // Sequencer: IDLE samples a request, MEM waits for flash or the watchdog, RESP acks once
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      rsp_d       = rsp_q;
      cnt_d       = cnt_q;
      timeout_d   = timeout_q;
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      if (state_q == IDLE) begin
         if (dbus_rd || i_ibus_cyc) begin
            sel_d   = dbus_rd;
            addr_d  = req_addr;
            cnt_d   = '0;
            rsp_d   = hit ? buf_data_q : rsp_q;
            state_d = hit ? RESP : MEM;
         end
      end else if (state_q == MEM) begin
         if (i_mem_ready) begin
            rsp_d       = i_mem_rdata;
            buf_data_d  = i_mem_rdata;
            buf_addr_d  = addr_q;
            buf_valid_d = 1'b1;
            state_d     = RESP;
         end else if (cnt_q == CNT_MAX) begin
            rsp_d     = 32'hFFFF_FFFF;
            timeout_d = 1'b1;
            state_d   = RESP;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         state_d = IDLE;
      end
      if (i_flush) buf_valid_d = 1'b0;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         addr_q      <= '0;
         rsp_q       <= '0;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         rsp_q       <= rsp_d;
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
      end
   end
endmodule

// File: tb/tb_underserved_mem_arb.sv
// tb_underserved_mem_arb: vector table, directed corner sequences and a random transaction-level model
module tb_underserved_mem_arb;
   localparam int AW   = 24;
   localparam int TO_A = 80;
   localparam int TO_B = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] ibus_adr = '0, dbus_adr = '0, dbus_dat = '0, rd_base = '0;
   logic [31:0] mem_rdata = '0;
   logic ibus_cyc = 1'b0, dbus_cyc = 1'b0, dbus_we = 1'b0, gpio_ack = 1'b0;
   logic mem_ready = 1'b0, flush = 1'b0, t_cyc = 1'b0;
   logic [31:0] ibus_rdt, dbus_rdt, t_ibus_rdt, t_dbus_rdt;
   logic ibus_ack, dbus_ack, gpio_stb, gpio_dat, mem_valid, timeout;
   logic t_ibus_ack, t_dbus_ack, t_gpio_stb, t_gpio_dat, t_valid, t_timeout;
   logic [AW-1:0] mem_addr, t_addr;
   int nchk = 0, nerr = 0;
   int cur_lat = 1, vcnt = 0;

   underserved_mem_arb #(.AW(AW), .TIMEOUT(TO_A), .BUF_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
      .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_we(dbus_we), .i_dbus_cyc(dbus_cyc),
      .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
      .o_gpio_stb(gpio_stb), .o_gpio_dat(gpio_dat), .i_gpio_ack(gpio_ack),
      .o_mem_valid(mem_valid), .o_mem_addr(mem_addr), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
      .i_flush(flush), .o_timeout(timeout)
   );

   underserved_mem_arb #(.AW(AW), .TIMEOUT(TO_B), .BUF_EN(1'b1)) u_to (
      .clk(clk), .rst_n(rst_n),
      .i_ibus_adr(ibus_adr), .i_ibus_cyc(t_cyc), .o_ibus_rdt(t_ibus_rdt), .o_ibus_ack(t_ibus_ack),
      .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_we(1'b0), .i_dbus_cyc(1'b0),
      .o_dbus_rdt(t_dbus_rdt), .o_dbus_ack(t_dbus_ack),
      .o_gpio_stb(t_gpio_stb), .o_gpio_dat(t_gpio_dat), .i_gpio_ack(1'b0),
      .o_mem_valid(t_valid), .o_mem_addr(t_addr), .i_mem_ready(1'b0), .i_mem_rdata(32'h0),
      .i_flush(flush), .o_timeout(t_timeout)
   );

   always #5 clk = ~clk;

   // Flash model: ready on the cur_lat-th cycle of valid, data derived from the address
   always @(negedge clk) begin
      if (mem_valid) begin
         vcnt = vcnt + 1;
         mem_ready = (vcnt == cur_lat);
         mem_rdata = rd_base + {8'h00, mem_addr};
      end else begin
         vcnt = 0;
         mem_ready = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic cyc, we, d0, gack, e_stb, e_dat, e_ack;
   } wvec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pulse_flush();
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
   endtask

   task automatic xact(input bit dsel, input logic [31:0] adr, input int lat,
                       output int nval, output int kack, output logic [31:0] rdt, output bit bad);
      logic [AW-1:0] ea;
      ea = adr[AW-1:0] & 24'hFFFFFC;
      nval = 0; kack = -1; rdt = '0; bad = 1'b0; cur_lat = lat;
      @(posedge clk); #1;
      if (dsel) begin dbus_adr = adr; dbus_we = 1'b0; dbus_cyc = 1'b1; end
      else begin ibus_adr = adr; ibus_cyc = 1'b1; end
      for (int k = 1; k <= 400 && kack < 0; k++) begin
         @(negedge clk);
         if (mem_valid) begin
            nval++;
            if (mem_addr !== ea) bad = 1'b1;
         end
         if (dsel ? ibus_ack : (dbus_ack && !dbus_we)) bad = 1'b1;
         if (dsel ? dbus_ack : ibus_ack) begin
            kack = k;
            rdt = dsel ? dbus_rdt : ibus_rdt;
         end
      end
      @(posedge clk); #1;
      if (dsel) dbus_cyc = 1'b0; else ibus_cyc = 1'b0;
      @(negedge clk);
      if (ibus_ack || (dbus_ack && !dbus_we)) bad = 1'b1;
   endtask

   task automatic t_fetch(input logic [31:0] adr, output int nval, output int kack, output logic [31:0] rdt);
      nval = 0; kack = -1; rdt = '0;
      @(posedge clk); #1 ibus_adr = adr; t_cyc = 1'b1;
      for (int k = 1; k <= 100 && kack < 0; k++) begin
         @(negedge clk);
         if (t_valid) nval++;
         if (t_ibus_ack) begin kack = k; rdt = t_ibus_rdt; end
      end
      @(posedge clk); #1 t_cyc = 1'b0;
   endtask

   initial begin
      wvec_t wv[6];
      int nv, k, kd, ki;
      logic [31:0] r, rd, ri, adr, ed;
      logic [AW-1:0] fa, a, ba;
      logic [31:0] bd;
      logic [31:0] cand[6];
      bit b, wrong, fa_set, bv, tom, ds;
      int lat, env, ek;

      wv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      wv[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      wv[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      wv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      wv[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      wv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      cand = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C, 32'h0100_0004, 32'h00FF_FFF0};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid", {31'h0, mem_valid}, 32'h0);
      chk("rst_iack", {31'h0, ibus_ack}, 32'h0);
      chk("rst_dack", {31'h0, dbus_ack}, 32'h0);
      chk("rst_timeout", {31'h0, timeout}, 32'h0);
      chk("rst_rdt", ibus_rdt, 32'h0);
      chk("rst_addr", {8'h0, mem_addr}, 32'h0);

      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         dbus_cyc = wv[i].cyc; dbus_we = wv[i].we; gpio_ack = wv[i].gack;
         dbus_dat = $urandom; dbus_dat[0] = wv[i].d0;
         @(negedge clk);
         chk($sformatf("wr_stb[%0d]", i), {31'h0, gpio_stb}, {31'h0, wv[i].e_stb});
         chk($sformatf("wr_dat[%0d]", i), {31'h0, gpio_dat}, {31'h0, wv[i].e_dat});
         chk($sformatf("wr_ack[%0d]", i), {31'h0, dbus_ack}, {31'h0, wv[i].e_ack});
         chk($sformatf("wr_novalid[%0d]", i), {31'h0, mem_valid}, 32'h0);
      end
      @(posedge clk); #1 dbus_cyc = 1'b0; dbus_we = 1'b0; gpio_ack = 1'b0; dbus_dat = '0;

      rd_base = 32'h1234_5674;
      xact(1'b0, 32'h0000_0004, 70, nv, k, r, b);
      chk("cold_nvalid", nv, 70);
      chk("cold_kack", k, 72);
      chk("cold_rdt", r, 32'h1234_5678);
      chk("cold_bad", {31'h0, b}, 32'h0);

      rd_base = 32'h0;
      xact(1'b0, 32'h0000_0006, 70, nv, k, r, b);
      chk("hit_nvalid", nv, 0);
      chk("hit_kack", k, 2);
      chk("hit_rdt", r, 32'h1234_5678);
      chk("hit_bad", {31'h0, b}, 32'h0);

      pulse_flush();
      rd_base = 32'hA000_0000;
      xact(1'b0, 32'h0000_0006, 5, nv, k, r, b);
      chk("flush_nvalid", nv, 5);
      chk("flush_kack", k, 7);
      chk("flush_rdt", r, 32'hA000_0004);

      rd_base = 32'h5500_0000;
      fork
         xact(1'b0, 32'h0000_0080, 30, nv, k, r, b);
         begin
            repeat (8) @(posedge clk);
            #2 dbus_cyc = 1'b1; dbus_we = 1'b1; dbus_dat = 32'h1; gpio_ack = 1'b0;
            @(negedge clk);
            chk("gpio_stb", {31'h0, gpio_stb}, 32'h1);
            chk("gpio_dat", {31'h0, gpio_dat}, 32'h1);
            chk("gpio_ack0", {31'h0, dbus_ack}, 32'h0);
            chk("gpio_inmem", {31'h0, mem_valid}, 32'h1);
            @(posedge clk); #2 gpio_ack = 1'b1;
            @(negedge clk);
            chk("gpio_ack1", {31'h0, dbus_ack}, 32'h1);
            @(posedge clk); #2 dbus_cyc = 1'b0; dbus_we = 1'b0; gpio_ack = 1'b0;
         end
      join
      chk("gpio_i_nvalid", nv, 30);
      chk("gpio_i_kack", k, 32);
      chk("gpio_i_rdt", r, 32'h5500_0080);
      chk("gpio_i_bad", {31'h0, b}, 32'h0);

      pulse_flush();
      rd_base = 32'h3000_0000; cur_lat = 6;
      kd = -1; ki = -1; wrong = 1'b0; fa_set = 1'b0; fa = '0; rd = '0; ri = '0;
      @(posedge clk); #1;
      ibus_adr = 32'h100; dbus_adr = 32'h200; dbus_we = 1'b0; ibus_cyc = 1'b1; dbus_cyc = 1'b1;
      for (int n = 1; n <= 200 && ki < 0; n++) begin
         @(negedge clk);
         if (mem_valid && !fa_set) begin fa = mem_addr; fa_set = 1'b1; end
         if (ibus_ack) begin
            if (kd < 0) wrong = 1'b1;
            ki = n; ri = ibus_rdt;
         end
         if (dbus_ack) begin
            if (kd >= 0) wrong = 1'b1;
            kd = n; rd = dbus_rdt;
            @(posedge clk); #1 dbus_cyc = 1'b0;
         end
      end
      @(posedge clk); #1 ibus_cyc = 1'b0;
      chk("arb_first_addr", {8'h0, fa}, 32'h200);
      chk("arb_dack_cyc", kd, 8);
      chk("arb_iack_cyc", ki, 16);
      chk("arb_drdt", rd, 32'h3000_0200);
      chk("arb_irdt", ri, 32'h3000_0100);
      chk("arb_wrong", {31'h0, wrong}, 32'h0);

      t_fetch(32'h40, nv, k, r);
      chk("to_nvalid", nv, TO_B);
      chk("to_kack", k, TO_B + 2);
      chk("to_rdt", r, 32'hFFFF_FFFF);
      chk("to_flag", {31'h0, t_timeout}, 32'h1);
      t_fetch(32'h40, nv, k, r);
      chk("to_nofill_nvalid", nv, TO_B);
      chk("to_sticky", {31'h0, t_timeout}, 32'h1);
      chk("to_main_clear", {31'h0, timeout}, 32'h0);

      pulse_flush();
      bv = 1'b0; tom = 1'b0; ba = '0; bd = '0;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 4) == 0) begin pulse_flush(); bv = 1'b0; end
         adr = cand[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
         lat = $urandom_range(1, 90);
         ds = 1'($urandom_range(0, 1));
         rd_base = $urandom;
         a = adr[AW-1:0] & 24'hFFFFFC;
         if (bv && ba == a) begin env = 0; ek = 2; ed = bd; end
         else if (lat <= TO_A) begin env = lat; ek = lat + 2; ed = rd_base + {8'h0, a}; bv = 1'b1; ba = a; bd = ed; end
         else begin env = TO_A; ek = TO_A + 2; ed = 32'hFFFF_FFFF; tom = 1'b1; end
         xact(ds, adr, lat, nv, k, r, b);
         chk($sformatf("rnd%0d_nvalid", n), nv, env);
         chk($sformatf("rnd%0d_kack", n), k, ek);
         chk($sformatf("rnd%0d_rdt", n), r, ed);
         chk($sformatf("rnd%0d_bad", n), {31'h0, b}, 32'h0);
         chk($sformatf("rnd%0d_timeout", n), {31'h0, timeout}, {31'h0, tom});
      end

      pulse_flush();
      rd_base = 32'h7700_0000;
      xact(1'b0, 32'h0000_00C0, 4, nv, k, r, b);
      chk("pre_rst_fill", nv, 4);
      @(posedge clk); #1 ibus_adr = 32'h300; ibus_cyc = 1'b1; t_cyc = 1'b1; cur_lat = 1000;
      repeat (5) @(negedge clk);
      chk("mid_mem_valid", {31'h0, mem_valid}, 32'h1);
      chk("mid_mem_tvalid", {31'h0, t_valid}, 32'h1);
      @(posedge clk); #1 rst_n = 1'b0; ibus_cyc = 1'b0; t_cyc = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_valid", {31'h0, mem_valid}, 32'h0);
      chk("rst_mid_tvalid", {31'h0, t_valid}, 32'h0);
      chk("rst_mid_timeout", {31'h0, timeout}, 32'h0);
      chk("rst_mid_ttimeout", {31'h0, t_timeout}, 32'h0);
      chk("rst_mid_addr", {8'h0, mem_addr}, 32'h0);
      chk("rst_mid_rdt", ibus_rdt, 32'h0);
      xact(1'b0, 32'h0000_00C0, 5, nv, k, r, b);
      chk("post_rst_miss", nv, 5);
      chk("post_rst_kack", k, 7);
      chk("post_rst_rdt", r, 32'h7700_00C0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
